mem_access_arbiter: RTL and testbench

//  Sequences the single RAM port between two requesters: instruction fetch (IF) and load/store (LS).

---
 rtl/mem_access_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter.sv
// Arbitrates the single RAM port between instruction fetch (IF) and load/store (LS).
// It drives MAR/MDR/MFA/RW_RAM and waits for MFC. Define MEM_TIMEOUT_EN to enable the ACCESS timeout and the ERR pulse.
module mem_access_arbiter #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 15,
  parameter int TO_W           = 4
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              IF_REQ,
  input  logic [DATA_W-1:0] IF_ADDR,
  output logic              IF_DONE,
  input  logic              LS_REQ,
  input  logic              LS_WR,
  input  logic [DATA_W-1:0] LS_ADDR,
  input  logic [DATA_W-1:0] LS_WDATA,
  output logic              LS_DONE,
  output logic [DATA_W-1:0] RDATA,
  output logic [DATA_W-1:0] MAR_OUT,
  output logic [DATA_W-1:0] MDR_OUT,
  output logic              MFA,
  output logic              RW_RAM,
  input  logic              MFC,
  input  logic [DATA_W-1:0] RAM_DOUT,
  output logic              BUSY,
  output logic              ERR
);

  // state  | meaning
  // IDLE   | no transaction; requests sampled here
  // ACCESS | MFA high, waiting for MFC
  // DONE   | one-cycle completion pulse to the winner
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  if ((2 ** TO_W) <= TIMEOUT_CYCLES || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("TO_W cannot hold TIMEOUT_CYCLES");
  end

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mar, mar_nxt, mdr, mdr_nxt, rdata, rdata_nxt;
  logic              mfa, mfa_nxt, rw, rw_nxt;
  logic              if_done, if_done_nxt, ls_done, ls_done_nxt;
  logic              busy, busy_nxt;
  logic              last_ls, last_ls_nxt, grant_ls, grant_ls_nxt;
  logic              pick_ls;
`ifdef MEM_TIMEOUT_EN
  logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
  logic              err, err_nxt;
`endif

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state    <= S_IDLE;
      mar      <= '0;
      mdr      <= '0;
      rdata    <= '0;
      mfa      <= 1'b0;
      rw       <= 1'b1;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      busy     <= 1'b0;
      last_ls  <= 1'b1;
      grant_ls <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      to_cnt   <= '0;
      err      <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      mar      <= mar_nxt;
      mdr      <= mdr_nxt;
      rdata    <= rdata_nxt;
      mfa      <= mfa_nxt;
      rw       <= rw_nxt;
      if_done  <= if_done_nxt;
      ls_done  <= ls_done_nxt;
      busy     <= busy_nxt;
      last_ls  <= last_ls_nxt;
      grant_ls <= grant_ls_nxt;
`ifdef MEM_TIMEOUT_EN
      to_cnt   <= to_cnt_nxt;
      err      <= err_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    mar_nxt      = mar;
    mdr_nxt      = mdr;
    rdata_nxt    = rdata;
    mfa_nxt      = mfa;
    rw_nxt       = rw;
    if_done_nxt  = 1'b0;
    ls_done_nxt  = 1'b0;
    last_ls_nxt  = last_ls;
    grant_ls_nxt = grant_ls;
    // On a tie LS wins only when IF was granted last.
    pick_ls      = LS_REQ && (!IF_REQ || !last_ls);
`ifdef MEM_TIMEOUT_EN
    to_cnt_nxt   = to_cnt;
    err_nxt      = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (IF_REQ || LS_REQ) begin
          grant_ls_nxt = pick_ls;
          last_ls_nxt  = pick_ls;
          mfa_nxt      = 1'b1;
          state_nxt    = S_ACCESS;
`ifdef MEM_TIMEOUT_EN
          to_cnt_nxt   = '0;
`endif
          if (pick_ls) begin
            mar_nxt = LS_ADDR;
            rw_nxt  = ~LS_WR;
            if (LS_WR) mdr_nxt = LS_WDATA;
          end else begin
            mar_nxt = IF_ADDR;
            rw_nxt  = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        if (MFC) begin
          if (rw) rdata_nxt = RAM_DOUT;
          mfa_nxt     = 1'b0;
          if_done_nxt = ~grant_ls;
          ls_done_nxt = grant_ls;
          state_nxt   = S_DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          mfa_nxt     = 1'b0;
          if_done_nxt = ~grant_ls;
          ls_done_nxt = grant_ls;
          err_nxt     = 1'b1;
          state_nxt   = S_DONE;
        end else begin
          to_cnt_nxt  = to_cnt + 1'b1;
        end
`endif
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        mfa_nxt   = 1'b0;
      end
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  assign MAR_OUT = mar;
  assign MDR_OUT = mdr;
  assign RDATA   = rdata;
  assign MFA     = mfa;
  assign RW_RAM  = rw;
  assign IF_DONE = if_done;
  assign LS_DONE = ls_done;
  assign BUSY    = busy;
`ifdef MEM_TIMEOUT_EN
  assign ERR     = err;
`else
  assign ERR     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Testbench for mem_access_arbiter. A queue of expected grants comes from a transaction-level model.
// A negedge monitor pops that queue and compares it with every DONE pulse and every MFA rise.
module tb_mem_access_arbiter;

  logic        CLK = 1'b0;
  logic        CLR, IF_REQ, LS_REQ, LS_WR, MFC;
  logic [31:0] IF_ADDR, LS_ADDR, LS_WDATA, RAM_DOUT;
  logic        IF_DONE, LS_DONE, MFA, RW_RAM, BUSY, ERR;
  logic [31:0] RDATA, MAR_OUT, MDR_OUT;

  mem_access_arbiter dut (
    .CLK(CLK), .CLR(CLR), .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_DONE(IF_DONE),
    .LS_REQ(LS_REQ), .LS_WR(LS_WR), .LS_ADDR(LS_ADDR), .LS_WDATA(LS_WDATA),
    .LS_DONE(LS_DONE), .RDATA(RDATA), .MAR_OUT(MAR_OUT), .MDR_OUT(MDR_OUT),
    .MFA(MFA), .RW_RAM(RW_RAM), .MFC(MFC), .RAM_DOUT(RAM_DOUT), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0], 16'hC0DE} ^ 32'h1234_5678;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    bit          is_if;
    logic [31:0] addr;
    bit          rw;
    logic [31:0] mdr;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] m_rdata, m_mdr;
  bit          m_last_ls;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic void model_reset();
    m_rdata   = 0;
    m_mdr     = 0;
    m_last_ls = 1;
  endfunction

  function automatic void model_grant(input bit is_if, input bit wr, input logic [31:0] a,
                                      input logic [31:0] wd, input bit tmo);
    exp_t e;
    e.is_if = is_if;
    e.addr  = a;
    e.rw    = is_if ? 1'b1 : !wr;
    if (!e.rw) begin
      m_mdr = wd;
      if (!tmo) ref_mem[a] = wd;
    end else if (!tmo) begin
      m_rdata = ref_rd(a);
    end
    e.mdr     = m_mdr;
    e.rdata   = m_rdata;
    e.err     = tmo;
    m_last_ls = !is_if;
    sb.push_back(e);
  endfunction

  function automatic void model_issue(input bit rq_if, input bit rq_ls, input bit wr,
                                      input logic [31:0] a_if, input logic [31:0] a_ls,
                                      input logic [31:0] wd, input bit tmo);
    if (rq_if && rq_ls) begin
      if (m_last_ls) begin
        model_grant(1, 0, a_if, 0, tmo);
        model_grant(0, wr, a_ls, wd, tmo);
      end else begin
        model_grant(0, wr, a_ls, wd, tmo);
        model_grant(1, 0, a_if, 0, tmo);
      end
    end else if (rq_if) model_grant(1, 0, a_if, 0, tmo);
    else if (rq_ls)     model_grant(0, wr, a_ls, wd, tmo);
  endfunction

  // ---------------- RAM model ----------------
  logic [31:0] ram[logic [31:0]];
  bit ram_en   = 1;
  int delay_lo = 0, delay_hi = 0, cur_delay = 0, wait_cnt = 0;

  initial begin
    MFC = 0;
    RAM_DOUT = 0;
    forever begin
      @(negedge CLK);
      if (ram_en) begin
        if (MFA && !MFC) begin
          if (wait_cnt >= cur_delay) begin
            MFC = 1;
            if (RW_RAM) RAM_DOUT = ram.exists(MAR_OUT) ? ram[MAR_OUT] : init_val(MAR_OUT);
            else ram[MAR_OUT] = MDR_OUT;
          end else wait_cnt++;
        end else if (!MFA) begin
          MFC       = 0;
          wait_cnt  = 0;
          cur_delay = $urandom_range(delay_hi, delay_lo);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic mfa_q = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (MFA && !mfa_q && sb.size() > 0) begin
        chk("mar", MAR_OUT, sb[0].addr);
        chk("rw_ram", {31'b0, RW_RAM}, {31'b0, sb[0].rw});
        chk("mdr", MDR_OUT, sb[0].mdr);
      end
      if (IF_DONE || LS_DONE) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got IF_DONE=%b LS_DONE=%b expected none", IF_DONE, LS_DONE);
        end else begin
          e = sb.pop_front();
          chk("done_who", {30'b0, IF_DONE, LS_DONE}, e.is_if ? 32'd2 : 32'd1);
          chk("rdata", RDATA, e.rdata);
          chk("err", {31'b0, ERR}, {31'b0, e.err});
          chk("mfa_in_done", {31'b0, MFA}, 32'd0);
        end
      end
      mfa_q = MFA;
    end
  end

  // ---------------- driver ----------------
  task automatic run_txn(input bit do_if, input bit do_ls, input bit wr,
                         input logic [31:0] a_if, input logic [31:0] a_ls,
                         input logic [31:0] wd, input bit tmo,
                         output int mfa_cyc, output int gap);
    bit pend_if, pend_ls, first_done;
    int budget;
    @(negedge CLK);
    model_issue(do_if, do_ls, wr, a_if, a_ls, wd, tmo);
    IF_REQ = do_if; IF_ADDR = a_if;
    LS_REQ = do_ls; LS_WR = wr; LS_ADDR = a_ls; LS_WDATA = wd;
    pend_if = do_if; pend_ls = do_ls; first_done = 0;
    mfa_cyc = 0; gap = 0; budget = 0;
    while ((pend_if || pend_ls) && budget < 300) begin
      @(negedge CLK);
      budget++;
      if (MFA) mfa_cyc++;
      if (first_done && !BUSY) gap++;
      if (IF_DONE && pend_if) begin IF_REQ = 0; pend_if = 0; first_done = 1; end
      if (LS_DONE && pend_ls) begin LS_REQ = 0; pend_ls = 0; first_done = 1; end
    end
    if (pend_if || pend_ls) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout: got no DONE within %0d cycles expected DONE", budget);
      IF_REQ = 0;
      LS_REQ = 0;
    end
  endtask

  initial begin
    int mc, gp, good;
    logic [31:0] ai, al, wd;
    CLR = 1; IF_REQ = 0; LS_REQ = 0; LS_WR = 0;
    IF_ADDR = 0; LS_ADDR = 0; LS_WDATA = 0;
    model_reset();
    ram[32'h10]     = 32'hE201_0000;
    ref_mem[32'h10] = 32'hE201_0000;
    repeat (2) @(negedge CLK);
    chk("rst_mfa", {31'b0, MFA}, 0);
    chk("rst_rw", {31'b0, RW_RAM}, 1);
    chk("rst_mar", MAR_OUT, 0);
    chk("rst_mdr", MDR_OUT, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_flags", {28'b0, IF_DONE, LS_DONE, BUSY, ERR}, 0);

    // tie from reset: IF first, then LS, then IF/LS again
    CLR = 0;
    delay_lo = 0; delay_hi = 0;
    run_txn(1, 1, 0, 32'h10, 32'h18, 0, 0, mc, gp);
    chk("tie_gap1", gp, 1);
    run_txn(1, 1, 1, 32'h14, 32'h1C, 32'h5555_AAAA, 0, mc, gp);
    chk("tie_gap2", gp, 1);

    // directed fetch with exact latency
    @(negedge CLK);
    model_issue(1, 0, 0, 32'h10, 0, 0, 0);
    IF_REQ = 1; IF_ADDR = 32'h10;
    @(negedge CLK);
    chk("f_mfa_busy", {30'b0, MFA, BUSY}, 3);
    chk("f_mar", MAR_OUT, 32'h10);
    @(negedge CLK);
    chk("f_done", {29'b0, IF_DONE, LS_DONE, MFA}, 32'd4);
    IF_REQ = 0;
    @(negedge CLK);
    chk("f_after", {30'b0, IF_DONE, BUSY}, 0);
    chk("f_rdata", RDATA, 32'hE201_0000);

    // store with MFC four cycles after MFA
    delay_lo = 4; delay_hi = 4;
    run_txn(0, 1, 1, 0, 32'h20, 32'hDEAD_BEEF, 0, mc, gp);
    chk("st_mfa_cycles", mc, 5);
    chk("st_rdata", RDATA, 32'hE201_0000);

    // random traffic
    delay_lo = 0; delay_hi = 3;
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(2, 0);
      ai = $urandom_range(7, 0) * 4;
      al = $urandom_range(7, 0) * 4;
      wd = $urandom;
      run_txn(kind != 1, kind != 0, $urandom_range(1, 0), ai, al, wd, 0, mc, gp);
      if (kind == 2) chk("rnd_gap", gp, 1);
      repeat ($urandom_range(2, 0)) @(negedge CLK);
    end

    // stray MFC in IDLE
    ram_en = 0; MFC = 0;
    @(negedge CLK);
    MFC = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("stray_flags", {28'b0, MFA, IF_DONE, LS_DONE, BUSY}, 0);
      chk("stray_rdata", RDATA, m_rdata);
    end
    MFC = 0;

    // reset during ACCESS
    @(negedge CLK);
    model_issue(0, 1, 0, 0, 32'h8, 0, 0);
    LS_REQ = 1; LS_WR = 0; LS_ADDR = 32'h8;
    @(negedge CLK);
    chk("abort_mfa", {31'b0, MFA}, 1);
    CLR = 1;
    @(negedge CLK);
    chk("abort_state", {28'b0, MFA, BUSY, IF_DONE, LS_DONE}, 0);
    CLR = 0; LS_REQ = 0;
    sb.delete();
    model_reset();
    MFC = 1;
    @(negedge CLK);
    MFC = 0;
    repeat (3) begin
      @(negedge CLK);
      chk("abort_after", {28'b0, MFA, BUSY, IF_DONE, LS_DONE}, 0);
    end

    // MFC never arrives
`ifdef MEM_TIMEOUT_EN
    run_txn(1, 0, 0, 32'h14, 0, 0, 1, mc, gp);
    chk("to_mfa_cycles", mc, 15);
`else
    @(negedge CLK);
    model_issue(1, 0, 0, 32'h14, 0, 0, 1);
    IF_REQ = 1; IF_ADDR = 32'h14;
    good = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (MFA && BUSY && !ERR && !IF_DONE) good++;
    end
    chk("hang_cycles", good, 100);
    CLR = 1; IF_REQ = 0;
    @(negedge CLK);
    CLR = 0;
    sb.delete();
    model_reset();
`endif

    repeat (3) @(negedge CLK);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
